frame_scanner: RTL and testbench

FRAME_SCANNER -- requirements
Module: frame_scanner

---
 rtl/frame_scanner_pkg.sv | 25 ++
 rtl/frame_scanner_fifo.sv | 77 +++++++
 rtl/frame_scanner.sv | 180 ++++++++++++++++++
 tb/tb_frame_scanner.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_scanner_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_scanner_pkg : shared geometry defaults and FSM encoding for frame_scanner
// Rev 1.0
// ----------------------------------------------------------------------------
package frame_scanner_pkg;

  localparam int unsigned DEF_PX_WIDTH  = 640;
  localparam int unsigned DEF_PX_HEIGHT = 480;
  localparam int unsigned DEF_PIX_BITS  = 3;
  localparam int unsigned DEF_ADDR_W    = 19;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } scan_state_e;

  // Pointer width for a circular buffer of n entries (at least one bit).
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_scanner_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// scan_fifo : synchronous FIFO with occupancy count and synchronous flush
// Rev 1.0
// ----------------------------------------------------------------------------
module scan_fifo
  import frame_scanner_pkg::*;
#(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic                       flush,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned      PTR_W    = ptr_width(DEPTH);
  localparam int unsigned      CNT_W    = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_wr, do_rd;

  always_comb begin
    do_wr    = wr_en && (count_q != FULL_CNT) && !flush;
    do_rd    = rd_en && (count_q != '0) && !flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      // Simultaneous push and pop leave the occupancy where it was.
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule
`default_nettype wire

// File: rtl/frame_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// frame_scanner : raster scan of a pixel memory into a ready/valid pixel stream
// Rev 1.0
// ----------------------------------------------------------------------------
module frame_scanner
  import frame_scanner_pkg::*;
#(
  parameter int unsigned PX_WIDTH   = DEF_PX_WIDTH,
  parameter int unsigned PX_HEIGHT  = DEF_PX_HEIGHT,
  parameter int unsigned PIX_BITS   = DEF_PIX_BITS,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                cont,
  input  logic                abort,
  output logic                mem_rd,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic [PIX_BITS-1:0] mem_data,
  output logic [PIX_BITS-1:0] px_data,
  output logic                px_valid,
  input  logic                px_ready,
  output logic                px_eol,
  output logic                px_eof,
  output logic                busy,
  output logic                done,
  output logic [15:0]         frame_cnt
);

  localparam int unsigned       N_PIX      = PX_WIDTH * PX_HEIGHT;
  localparam int unsigned       X_W        = ptr_width(PX_WIDTH);
  localparam int unsigned       CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned       FW         = PIX_BITS + 2;
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(N_PIX - 1);
  localparam logic [X_W-1:0]    LAST_X     = X_W'(PX_WIDTH - 1);
  localparam logic [CNT_W:0]    CREDIT_MAX = (CNT_W + 1)'(FIFO_DEPTH);

  scan_state_e       state_q, state_d;
  logic              cont_q, cont_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
  logic [RD_LAT-1:0] pipe_eol_q, pipe_eol_d;
  logic [RD_LAT-1:0] pipe_eof_q, pipe_eof_d;

  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic [FW-1:0]     fifo_rd_data;
  logic              credit_ok;
  logic              issue;
  logic              xfer;
  logic              head_eol, head_eof;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + CNT_W'(pipe_v_q[i]);
  end

  // Reads already in flight reserve a FIFO slot, so the buffer can never overflow.
  assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < CREDIT_MAX;
  assign xfer      = px_valid && px_ready;

  always_comb begin
    state_d     = state_q;
    cont_d      = cont_q;
    addr_d      = addr_q;
    x_d         = x_q;
    frame_cnt_d = frame_cnt_q;
    issue       = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          cont_d  = cont;
        end
      end
      ST_SCAN: begin
        issue = credit_ok;
        if (credit_ok) begin
          if (addr_q == LAST_ADDR) begin
            addr_d  = '0;
            x_d     = '0;
            state_d = ST_DRAIN;
          end else begin
            addr_d = addr_q + 1'b1;
            x_d    = (x_q == LAST_X) ? '0 : x_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer && px_eof) begin
          done        = 1'b1;
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = cont_q ? ST_SCAN : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d     = ST_IDLE;
      addr_d      = '0;
      x_d         = '0;
      issue       = 1'b0;
      done        = 1'b0;
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Tag pipeline tracks each read until its data returns RD_LAT cycles later.
  always_comb begin
    pipe_v_d      = pipe_v_q;
    pipe_eol_d    = pipe_eol_q;
    pipe_eof_d    = pipe_eof_q;
    pipe_v_d[0]   = issue;
    pipe_eol_d[0] = (x_q == LAST_X);
    pipe_eof_d[0] = (addr_q == LAST_ADDR);
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_eol_d[i] = pipe_eol_q[i-1];
      pipe_eof_d[i] = pipe_eof_q[i-1];
    end
    if (abort) pipe_v_d = '0;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q     <= ST_IDLE;
      cont_q      <= 1'b0;
      addr_q      <= '0;
      x_q         <= '0;
      frame_cnt_q <= '0;
      pipe_v_q    <= '0;
      pipe_eol_q  <= '0;
      pipe_eof_q  <= '0;
    end else begin
      state_q     <= state_d;
      cont_q      <= cont_d;
      addr_q      <= addr_d;
      x_q         <= x_d;
      frame_cnt_q <= frame_cnt_d;
      pipe_v_q    <= pipe_v_d;
      pipe_eol_q  <= pipe_eol_d;
      pipe_eof_q  <= pipe_eof_d;
    end
  end

  scan_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clr     (clr),
    .flush   (abort),
    .wr_en   (pipe_v_q[RD_LAT-1]),
    .wr_data ({mem_data, pipe_eol_q[RD_LAT-1], pipe_eof_q[RD_LAT-1]}),
    .rd_en   (xfer),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign {px_data, head_eol, head_eof} = fifo_rd_data;
  assign px_valid  = !fifo_empty;
  // Storage is not reset, so tags are qualified to stay low with an empty FIFO.
  assign px_eol    = px_valid && head_eol;
  assign px_eof    = px_valid && head_eof;
  assign mem_rd    = issue;
  assign mem_addr  = addr_q;
  assign busy      = (state_q != ST_IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_scanner.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_frame_scanner : directed bench, 4x3 frame at RD_LAT=2 and 1x1 frame at RD_LAT=4
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_frame_scanner;

  localparam int AW    = 4;
  localparam int AH    = 3;
  localparam int NPIX  = AW * AH;
  localparam int ALAT  = 2;
  localparam int DEPTH = 8;
  localparam int BLAT  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clr;
  logic        a_start, a_cont, a_abort, a_px_ready;
  logic        a_mem_rd, a_px_valid, a_px_eol, a_px_eof, a_busy, a_done;
  logic [3:0]  a_mem_addr;
  logic [2:0]  a_mem_data, a_px_data;
  logic [15:0] a_frame_cnt;

  logic        b_start, b_cont, b_abort, b_px_ready;
  logic        b_mem_rd, b_px_valid, b_px_eol, b_px_eof, b_busy, b_done;
  logic [0:0]  b_mem_addr;
  logic [2:0]  b_mem_data, b_px_data;
  logic [15:0] b_frame_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  // Memory models: A returns addr[2:0] ALAT cycles after the read; B returns 5 only for a real read.
  logic [3:0]      a_dly [ALAT];
  logic [BLAT-1:0] b_v;
  always @(posedge clk) begin
    a_dly[0] <= a_mem_addr;
    a_dly[1] <= a_dly[0];
    b_v      <= {b_v[BLAT-2:0], b_mem_rd};
  end
  assign a_mem_data = a_dly[ALAT-1][2:0];
  assign b_mem_data = b_v[BLAT-1] ? 3'd5 : 3'd0;

  frame_scanner #(
    .PX_WIDTH(AW), .PX_HEIGHT(AH), .PIX_BITS(3), .ADDR_W(4), .RD_LAT(ALAT), .FIFO_DEPTH(DEPTH)
  ) u_dut_a (
    .clk(clk), .clr(clr), .start(a_start), .cont(a_cont), .abort(a_abort),
    .mem_rd(a_mem_rd), .mem_addr(a_mem_addr), .mem_data(a_mem_data),
    .px_data(a_px_data), .px_valid(a_px_valid), .px_ready(a_px_ready),
    .px_eol(a_px_eol), .px_eof(a_px_eof), .busy(a_busy), .done(a_done),
    .frame_cnt(a_frame_cnt)
  );

  frame_scanner #(
    .PX_WIDTH(1), .PX_HEIGHT(1), .PIX_BITS(3), .ADDR_W(1), .RD_LAT(BLAT), .FIFO_DEPTH(DEPTH)
  ) u_dut_b (
    .clk(clk), .clr(clr), .start(b_start), .cont(b_cont), .abort(b_abort),
    .mem_rd(b_mem_rd), .mem_addr(b_mem_addr), .mem_data(b_mem_data),
    .px_data(b_px_data), .px_valid(b_px_valid), .px_ready(b_px_ready),
    .px_eol(b_px_eol), .px_eof(b_px_eof), .busy(b_busy), .done(b_done),
    .frame_cnt(b_frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Start DUT A (cycle 0) and follow it until n_frames*NPIX pixels or stop_at pixels transfer.
  task automatic scan_a(input int n_frames, input bit cont_in, input bit toggle,
                        input int hold, input int stop_at);
    int cyc, pix, issued, first_rd, first_valid, dones, idle_cyc, max_out, hold_rds, k;
    cyc = 0; pix = 0; issued = 0; first_rd = -1; first_valid = -1;
    dones = 0; idle_cyc = 0; max_out = 0; hold_rds = 0;
    @(negedge clk);
    a_start = 1'b1; a_cont = cont_in; a_px_ready = (hold == 0);
    #1;
    while (pix < n_frames * NPIX && pix != stop_at && cyc < 300) begin
      @(negedge clk);
      cyc++;
      a_start = 1'b0; a_cont = 1'b0;
      a_px_ready = (cyc <= hold) ? 1'b0 : (toggle ? cyc[0] : 1'b1);
      #1;
      if (a_mem_rd) begin
        chk("mem_addr_order", 32'(a_mem_addr), issued % NPIX);
        if (first_rd < 0) first_rd = cyc;
        if (cyc <= hold) hold_rds++;
        issued++;
      end
      if (issued - pix > max_out) max_out = issued - pix;
      if (!a_busy) idle_cyc++;
      if (a_done) dones++;
      if (a_px_valid && first_valid < 0) first_valid = cyc;
      if (a_px_valid && a_px_ready) begin
        k = pix % NPIX;
        chk("px_data", 32'(a_px_data), k % 8);
        chk("px_eol", 32'(a_px_eol), 32'((k % AW) == AW - 1));
        chk("px_eof", 32'(a_px_eof), 32'(k == NPIX - 1));
        chk("done_with_eof", 32'(a_done), 32'(k == NPIX - 1));
        pix++;
      end
    end
    chk("scan_within_budget", 32'(cyc < 300), 1);
    chk("first_mem_rd_cycle", first_rd, 1);
    chk("first_px_valid_cycle", first_valid, ALAT + 2);
    if (stop_at < 0) begin
      chk("done_pulses", dones, n_frames);
      chk("idle_cycles_in_run", idle_cyc, 0);
      chk("outstanding_le_depth", 32'(max_out <= DEPTH), 1);
    end
    if (hold > 0) chk("reads_until_credit_stall", hold_rds, DEPTH);
  endtask

  initial begin
    int dcount, bcyc, bfirst, brds, bxfer;
    clr = 1'b0;
    a_start = 0; a_cont = 0; a_abort = 0; a_px_ready = 1;
    b_start = 0; b_cont = 0; b_abort = 0; b_px_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_px_valid", 32'(a_px_valid), 0);
    chk("rst_mem_rd", 32'(a_mem_rd), 0);
    chk("rst_done", 32'(a_done), 0);
    chk("rst_px_eol_eof", 32'({a_px_eol, a_px_eof}), 0);
    chk("rst_mem_addr", 32'(a_mem_addr), 0);
    chk("rst_frame_cnt", 32'(a_frame_cnt), 0);
    chk("rst_b_busy", 32'(b_busy), 0);
    @(negedge clk);
    clr = 1'b1;

    // Single frame, consumer always ready.
    scan_a(1, 1'b0, 1'b0, 0, -1);
    @(negedge clk); #1;
    chk("busy_after_frame", 32'(a_busy), 0);
    chk("frame_cnt_1", 32'(a_frame_cnt), 1);

    // Consumer ready alternating 1,0.
    scan_a(1, 1'b0, 1'b1, 0, -1);
    @(negedge clk); #1;
    chk("frame_cnt_2", 32'(a_frame_cnt), 2);

    // Consumer stalled for 12 cycles: reads must stop at FIFO_DEPTH.
    scan_a(1, 1'b0, 1'b0, 12, -1);
    @(negedge clk); #1;
    chk("frame_cnt_3", 32'(a_frame_cnt), 3);

    // Continuous mode, two frames back to back, then abort the third.
    scan_a(2, 1'b1, 1'b0, 0, -1);
    @(negedge clk); #1;
    chk("cont_still_busy", 32'(a_busy), 1);
    chk("frame_cnt_5", 32'(a_frame_cnt), 5);
    @(negedge clk); a_abort = 1'b1; #1;
    @(negedge clk); a_abort = 1'b0; #1;
    chk("cont_abort_busy", 32'(a_busy), 0);
    chk("cont_abort_px_valid", 32'(a_px_valid), 0);

    // Abort after the 5th pixel.
    scan_a(1, 1'b0, 1'b0, 0, 5);
    @(negedge clk); a_abort = 1'b1; #1;
    chk("abort_no_done", 32'(a_done), 0);
    @(negedge clk); a_abort = 1'b0; #1;
    chk("abort_busy", 32'(a_busy), 0);
    chk("abort_px_valid", 32'(a_px_valid), 0);
    chk("abort_mem_rd", 32'(a_mem_rd), 0);
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      if (a_done || a_px_valid) dcount++;
    end
    chk("abort_quiet_after", dcount, 0);
    chk("abort_frame_cnt_kept", 32'(a_frame_cnt), 5);
    scan_a(1, 1'b0, 1'b0, 0, -1);
    @(negedge clk); #1;
    chk("frame_cnt_after_restart", 32'(a_frame_cnt), 6);

    // Abort wins over start in the same cycle.
    @(negedge clk); a_start = 1'b1; a_abort = 1'b1; #1;
    @(negedge clk); a_start = 1'b0; a_abort = 1'b0; #1;
    chk("abort_over_start_busy", 32'(a_busy), 0);
    chk("abort_over_start_rd", 32'(a_mem_rd), 0);

    // Asynchronous reset in the middle of a scan.
    @(negedge clk); a_start = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); a_start = 1'b0; #1;
    end
    chk("pre_reset_busy", 32'(a_busy), 1);
    #1 clr = 1'b0;
    #1;
    chk("async_rst_busy", 32'(a_busy), 0);
    chk("async_rst_mem_rd", 32'(a_mem_rd), 0);
    chk("async_rst_px_valid", 32'(a_px_valid), 0);
    chk("async_rst_mem_addr", 32'(a_mem_addr), 0);
    chk("async_rst_frame_cnt", 32'(a_frame_cnt), 0);
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("post_reset_waits", 32'(a_busy), 0);
    scan_a(1, 1'b0, 1'b0, 0, -1);
    @(negedge clk); #1;
    chk("frame_cnt_after_reset", 32'(a_frame_cnt), 1);

    // 1x1 frame with RD_LAT=4.
    @(negedge clk); b_start = 1'b1; #1;
    bcyc = 0; bfirst = -1; brds = 0; bxfer = 0;
    while (bxfer == 0 && bcyc < 40) begin
      @(negedge clk); bcyc++; b_start = 1'b0; #1;
      if (b_mem_rd) brds++;
      if (b_px_valid && bfirst < 0) bfirst = bcyc;
      if (b_px_valid && b_px_ready) begin
        chk("b_px_data", 32'(b_px_data), 5);
        chk("b_px_eol", 32'(b_px_eol), 1);
        chk("b_px_eof", 32'(b_px_eof), 1);
        chk("b_done", 32'(b_done), 1);
        bxfer = 1;
      end
    end
    chk("b_pixel_seen", bxfer, 1);
    chk("b_first_px_valid_cycle", bfirst, BLAT + 2);
    chk("b_read_count", brds, 1);
    @(negedge clk); #1;
    chk("b_frame_cnt", 32'(b_frame_cnt), 1);
    chk("b_busy_after", 32'(b_busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
